fp32_result_deser: RTL and testbench
====================================

// Module: fp32_result_deser
// PURPOSE
//   Downstream companion of the serial fp32 adder (add_float). Samples the adder's
//   bit-serial sum (out_c, MSB first, qualified by shift). When done is seen, it
//   presents the 32-bit word and its over/under flags on a parallel valid/ready port.
//   It also detects framing errors and results that are dropped before the consumer
//   has read the previous one.
// PARAMETERS
//   WIDTH      32   serial word length in bits; the fp32 field decode below assumes 32
//   CNT_W      6    bit-counter width; must hold WIDTH+1 without wrapping
// PORTS
//   clk        in   1      rising-edge clock, shared with add_float
//   reset      in   1      asynchronous, active-low reset
//   shift      in   1      add_float: out_c carries a valid result bit this cycle
//   out_c      in   1      add_float: serial result bit, MSB first
//   over       in   1      add_float: overflow flag, sampled when done=1
//   under      in   1      add_float: underflow flag, sampled when done=1
//   done       in   1      add_float: end-of-result strobe, 1 cycle
//   result     out  WIDTH  assembled fp32 word
//   res_over   out  1      captured overflow flag
//   res_under  out  1      captured underflow flag
//   res_zero   out  1      result[30:0]==0
//   res_inf    out  1      exponent==8'hFF and mantissa==0
//   res_nan    out  1      exponent==8'hFF and mantissa!=0
//   res_valid  out  1      result and all res_* outputs are valid
//   res_ready  in   1      consumer accepts the word when res_valid && res_ready
//   frame_err  out  1      1-cycle pulse: done arrived with bit count != WIDTH
//   overrun    out  1      sticky: shift or done arrived while the HOLD state was full
// BEHAVIOUR
//   Reset (reset=0, async)
//     - All outputs are 0. State is IDLE. Bit counter and shift register are 0.
//   States: IDLE, COLLECT, HOLD
//   IDLE
//     - shift=1: sreg <= {sreg[WIDTH-2:0], out_c}, cnt <= 1, go to COLLECT.
//     - done=1 with shift=0: frame_err pulse (count 0), stay in IDLE.
//   COLLECT
//     - shift=1: shift in out_c. cnt increments and saturates at WIDTH+1,
//       so more than WIDTH bits always fails framing.
//     - shift and done in the same cycle: the bit is taken first, then the framing
//       check uses the incremented count.
//     - done=1 and the effective count == WIDTH:
//       result <= sreg, res_over <= over, res_under <= under,
//       decode flags are computed from the captured word, go to HOLD.
//       res_valid rises on the cycle after done (latency 1).
//     - done=1 and the effective count != WIDTH:
//       frame_err=1 for one cycle, cnt <= 0, back to IDLE.
//       result and res_valid are unchanged.
//   HOLD
//     - res_valid=1. result and res_* are stable until accepted.
//     - res_valid && res_ready: res_valid <= 0 on the next edge, go to IDLE.
//       The held result stays readable, but it is stale.
//     - shift or done while in HOLD:
//       the bits are dropped and overrun <= 1. overrun clears only on reset.
//     - res_ready and shift in the same cycle: the accept is taken and the bit is
//       dropped (overrun=1). The upstream stage must not shift before acceptance.
//   Outputs are registered; there is no combinational path from inputs to outputs.
//   over and under are ignored except in the done cycle.
//   An async reset during COLLECT or HOLD discards the partial or held word
//   immediately.
// TESTING
//   T1 Stream 0x3FC00000 MSB first, done with the 32nd bit, res_ready=1
//      -> next cycle result=0x3FC00000, res_valid=1, res_over=res_under=0,
//         then res_valid=0.
//   T2 Stream 0x00400000 with under=1 at done
//      -> result=0x00400000, res_under=1, res_zero=0.
//      Then stream 0x00000000 -> res_zero=1.
//   T3 Stream 0x7F800000 with over=1 -> res_inf=1, res_over=1.
//      Stream 0x7FC00000 -> res_nan=1, res_inf=0.
//   T4 Stream 31 bits then done -> frame_err 1-cycle pulse, res_valid stays 0.
//      Repeat with 40 bits -> frame_err pulse.
//   T5 res_ready=0 after a good word, then stream a second word
//      -> overrun=1, the first word is still held.
//      Raise res_ready -> accepted, state returns to IDLE.
//   T6 Assert reset=0 after 16 bits -> all outputs 0 asynchronously.
//      Release, stream 0xC0490FDB -> result=0xC0490FDB, no frame_err.

Source files
------------

// File: rtl/fp32_result_deser.sv
// Deserializer for the bit-serial fp32 adder result: collects MSB-first bits, checks
// framing on done, and holds the word with decode flags on a valid/ready port.
module fp32_result_deser #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             out_c,
  input  logic             over,
  input  logic             under,
  input  logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_over,
  output logic             res_under,
  output logic             res_zero,
  output logic             res_inf,
  output logic             res_nan,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_eff;
  logic             take_bit, capture, ferr, accept, drop;
  logic [2:0]       cls;

  // {zero, inf, nan} classification of an fp32 word; the sign bit is ignored
  function automatic logic [2:0] fp32_class(input logic [31:0] w);
    logic exp_ones;
    logic man_zero;
    exp_ones = (w[30:23] == 8'hFF);
    man_zero = (w[22:0] == 23'd0);
    return {(w[30:0] == 31'd0), exp_ones && man_zero, exp_ones && !man_zero};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: begin
        if (capture)       state_nxt = HOLD;
        else if (ferr)     state_nxt = IDLE;
        else if (take_bit) state_nxt = COLLECT;
      end
      HOLD:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: a bit arriving with done is shifted before the framing check
  always_comb begin
    take_bit = (state != HOLD) && shift;
    cnt_eff  = cnt;
    if (take_bit) cnt_eff = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    sreg_nxt = take_bit ? {sreg[WIDTH-2:0], out_c} : sreg;
    capture  = (state != HOLD) && done && (cnt_eff == CNT_FULL);
    ferr     = (state != HOLD) && done && (cnt_eff != CNT_FULL);
    accept   = (state == HOLD) && res_ready;
    drop     = (state == HOLD) && (shift || done);
    cls      = fp32_class(sreg_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg      <= '0;
      cnt       <= '0;
      result    <= '0;
      res_over  <= 1'b0;
      res_under <= 1'b0;
      res_zero  <= 1'b0;
      res_inf   <= 1'b0;
      res_nan   <= 1'b0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sreg      <= sreg_nxt;
      cnt       <= (capture || ferr) ? '0 : cnt_eff;
      frame_err <= ferr;
      overrun   <= overrun | drop;
      if (capture) begin
        result    <= sreg_nxt;
        res_over  <= over;
        res_under <= under;
        {res_zero, res_inf, res_nan} <= cls;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_result_deser.sv
// Bench for fp32_result_deser: table of framed words, random frames against a
// word-level model, and hand sequences for overrun and mid-frame reset.
module tb_fp32_result_deser;

  logic        clk = 1'b0;
  logic        reset;
  logic        shift, out_c, over, under, done, res_ready;
  logic [31:0] result;
  logic        res_over, res_under, res_zero, res_inf, res_nan, res_valid;
  logic        frame_err, overrun;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_good = 32'h0;

  fp32_result_deser #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .shift(shift), .out_c(out_c), .over(over),
    .under(under), .done(done), .result(result), .res_over(res_over),
    .res_under(res_under), .res_zero(res_zero), .res_inf(res_inf),
    .res_nan(res_nan), .res_valid(res_valid), .res_ready(res_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    logic        ov, un;
    logic        exp_ferr;
    logic [31:0] exp_res;
    logic        exp_over, exp_under, exp_zero, exp_inf, exp_nan;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame of nbits bits, MSB first, done together with the last bit
  task automatic send(input logic [31:0] w, input int nbits, input logic ov, input logic un);
    if (nbits == 0) begin
      shift = 1'b0; done = 1'b1; over = ov; under = un;
      tick();
    end else begin
      for (int i = 0; i < nbits; i++) begin
        shift = 1'b1;
        out_c = (i < 32) ? w[31-i] : 1'($urandom);
        done  = (i == nbits - 1);
        over  = done ? ov : 1'($urandom);
        under = done ? un : 1'($urandom);
        tick();
      end
    end
    shift = 1'b0; done = 1'b0; over = 1'b0; under = 1'b0; out_c = 1'b0;
  endtask

  // Reference classification from the IEEE-754 field definitions
  function automatic logic [2:0] ref_class(input logic [31:0] w);
    int unsigned e, m;
    e = (w >> 23) & 32'hFF;
    m = w & 32'h7FFFFF;
    return {(w & 32'h7FFFFFFF) == 0, (e == 255) && (m == 0), (e == 255) && (m != 0)};
  endfunction

  // Model-checked frame with res_ready held high
  task automatic model_frame(input logic [31:0] w, input int nbits, input logic ov, input logic un);
    logic       good;
    logic [2:0] c;
    good = (nbits == 32);
    c    = ref_class(w);
    send(w, nbits, ov, un);
    check("rnd_ferr", 32'(frame_err), 32'(!good));
    check("rnd_valid", 32'(res_valid), 32'(good));
    if (good) begin
      last_good = w;
      check("rnd_flags", {27'd0, res_over, res_under, res_zero, res_inf, res_nan},
            {27'd0, ov, un, c});
    end
    check("rnd_result", result, last_good);
    tick();
    check("rnd_after", {30'd0, res_valid, frame_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h3FC00000, 32, 0, 0, 0, 32'h3FC00000, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h00400000, 32, 0, 1, 0, 32'h00400000, 0, 1, 0, 0, 0};
    vecs[2]  = '{32'h00000000, 32, 0, 0, 0, 32'h00000000, 0, 0, 1, 0, 0};
    vecs[3]  = '{32'h7F800000, 32, 1, 0, 0, 32'h7F800000, 1, 0, 0, 1, 0};
    vecs[4]  = '{32'h7FC00000, 32, 0, 0, 0, 32'h7FC00000, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'h80000000, 32, 0, 1, 0, 32'h80000000, 0, 1, 1, 0, 0};
    vecs[6]  = '{32'hFF800001, 32, 1, 1, 0, 32'hFF800001, 1, 1, 0, 0, 1};
    vecs[7]  = '{32'h12345678, 31, 0, 0, 1, 32'hFF800001, 0, 0, 0, 0, 0};
    vecs[8]  = '{32'h12345678, 40, 1, 1, 1, 32'hFF800001, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h00000000,  0, 0, 0, 1, 32'hFF800001, 0, 0, 0, 0, 0};
    vecs[10] = '{32'hA5A5A5A5, 33, 0, 0, 1, 32'hFF800001, 0, 0, 0, 0, 0};
    vecs[11] = '{32'h00800000, 32, 0, 0, 0, 32'h00800000, 0, 0, 0, 0, 0};

    reset = 1'b0; shift = 1'b0; out_c = 1'b0; over = 1'b0; under = 1'b0;
    done = 1'b0; res_ready = 1'b1;
    tick(); tick();
    check("reset_result", result, 32'h0);
    check("reset_flags", {24'd0, res_over, res_under, res_zero, res_inf, res_nan,
          res_valid, frame_err, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 12; k++) begin
      send(vecs[k].word, vecs[k].nbits, vecs[k].ov, vecs[k].un);
      check($sformatf("v%0d_ferr", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
      check($sformatf("v%0d_valid", k), 32'(res_valid), 32'(!vecs[k].exp_ferr));
      check($sformatf("v%0d_result", k), result, vecs[k].exp_res);
      if (!vecs[k].exp_ferr)
        check($sformatf("v%0d_flags", k),
              {27'd0, res_over, res_under, res_zero, res_inf, res_nan},
              {27'd0, vecs[k].exp_over, vecs[k].exp_under, vecs[k].exp_zero,
               vecs[k].exp_inf, vecs[k].exp_nan});
      tick();
      check($sformatf("v%0d_after", k), {30'd0, res_valid, frame_err}, 32'd0);
    end
    last_good = 32'h00800000;

    for (int k = 0; k < 40; k++) begin
      logic [31:0] w;
      int          nb;
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[30:23] = 8'hFF;
        1: w[30:23] = 8'h00;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[22:0] = 23'd0;
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(29, 35)) : 32;
      model_frame(w, nb, 1'($urandom), 1'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        out_c = 1'($urandom); over = 1'($urandom); under = 1'($urandom);
        tick();
      end
      out_c = 1'b0; over = 1'b0; under = 1'b0;
    end
    check("no_overrun_yet", 32'(overrun), 32'd0);

    res_ready = 1'b0;
    send(32'h40490FDB, 32, 1'b0, 1'b0);
    check("hold_valid", 32'(res_valid), 32'd1);
    check("hold_result", result, 32'h40490FDB);
    tick(); tick();
    check("hold_stable", {res_valid, result[30:0]}, {1'b1, 31'h40490FDB});
    send(32'h3F800000, 32, 1'b1, 1'b1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_held", result, 32'h40490FDB);
    check("ovr_valid_noferr", {30'd0, res_valid, frame_err}, 32'd2);
    check("ovr_over_kept", {30'd0, res_over, res_under}, 32'd0);
    res_ready = 1'b1;
    tick();
    check("accept_valid", 32'(res_valid), 32'd0);
    check("accept_stale", result, 32'h40490FDB);
    last_good = 32'h40490FDB;
    model_frame(32'hBF000000, 32, 1'b0, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    for (int i = 0; i < 16; i++) begin
      shift = 1'b1; out_c = 1'($urandom);
      tick();
    end
    shift = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_result", result, 32'h0);
    check("async_flags", {24'd0, res_over, res_under, res_zero, res_inf, res_nan,
          res_valid, frame_err, overrun}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    last_good = 32'h0;
    model_frame(32'hC0490FDB, 32, 1'b0, 1'b0);
    check("post_reset_result", result, 32'hC0490FDB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
